// File: rtl/tetris_input_encoder.sv
// Button front end: sync, debounce, press edges, auto-repeat, held command.
// Auto-repeat is built only when TETRIS_AUTO_REPEAT_EN is defined.
module tetris_input_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 15000000,
    parameter int unsigned REPEAT_RATE     = 5000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] btn_raw,
    input  logic       cmd_ack,
    output logic [3:0] controller_out,
    output logic       cmd_pending,
    output logic [5:0] btn_state
);

    localparam logic [3:0] CMD_NONE      = 4'd0;
    localparam logic [3:0] CMD_LEFT      = 4'd1;
    localparam logic [3:0] CMD_RIGHT     = 4'd2;
    localparam logic [3:0] CMD_DOWN      = 4'd3;
    localparam logic [3:0] CMD_START     = 4'd4;
    localparam logic [3:0] CMD_ROTATE    = 4'd5;
    localparam logic [3:0] CMD_HARD_DROP = 4'd6;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES);

    logic [5:0]            sync1_q, sync2_q;
    logic [5:0]            state_q, state_d;
    logic [5:0]            prev_q;
    logic [5:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [5:0]            press;
    logic                  rep_fire;
    logic [3:0]            rep_code;
    logic [3:0]            ev_code;
    logic [3:0]            cmd_q, cmd_d;
    logic                  pend_q, pend_d;

    // A differing level must survive the terminal count once more before it flips.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = '0;
        for (int i = 0; i < 6; i++) begin
            if (sync2_q[i] != state_q[i]) begin
                if (db_cnt_q[i] == DB_TERM) begin
                    state_d[i] = ~state_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign press = state_q & ~prev_q;

`ifdef TETRIS_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_REPEAT
    } rep_state_e;

    localparam logic [CNT_W-1:0] DELAY_TERM = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_TERM  = CNT_W'(REPEAT_RATE - 1);

    rep_state_e       rep_state_q, rep_state_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]       rep_btn_q, rep_btn_d;
    logic [1:0]       arm_btn;
    logic [CNT_W-1:0] rep_term;

    assign arm_btn  = press[2] ? 2'd2 : (press[0] ? 2'd0 : 2'd1);
    assign rep_term = (rep_state_q == R_DELAY) ? DELAY_TERM : RATE_TERM;
    assign rep_code = {2'b00, rep_btn_q} + 4'd1;

    always_comb begin
        rep_state_d = rep_state_q;
        rep_cnt_d   = rep_cnt_q;
        rep_btn_d   = rep_btn_q;
        rep_fire    = 1'b0;
        if (|press[2:0]) begin
            rep_state_d = R_DELAY;
            rep_cnt_d   = '0;
            rep_btn_d   = arm_btn;
        end else begin
            unique case (rep_state_q)
                R_DELAY, R_REPEAT: begin
                    if (!state_q[rep_btn_q]) begin
                        rep_state_d = R_IDLE;
                        rep_cnt_d   = '0;
                    end else if (rep_cnt_q == rep_term) begin
                        rep_fire    = 1'b1;
                        rep_state_d = R_REPEAT;
                        rep_cnt_d   = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    rep_state_d = R_IDLE;
                    rep_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_state_q <= R_IDLE;
            rep_cnt_q   <= '0;
            rep_btn_q   <= 2'd0;
        end else begin
            rep_state_q <= rep_state_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_btn_q   <= rep_btn_d;
        end
    end
`else
    logic unused_rep_cfg;

    assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rep_fire       = 1'b0;
    assign rep_code       = CMD_NONE;
`endif

    always_comb begin
        ev_code = CMD_NONE;
        priority case (1'b1)
            press[4]: ev_code = CMD_START;
            press[3]: ev_code = CMD_ROTATE;
            press[5]: ev_code = CMD_HARD_DROP;
            press[2]: ev_code = CMD_DOWN;
            press[0]: ev_code = CMD_LEFT;
            press[1]: ev_code = CMD_RIGHT;
            rep_fire: ev_code = rep_code;
            default:  ev_code = CMD_NONE;
        endcase
    end

    // An idle slot always reflects the winner, so no event also means clear.
    always_comb begin
        cmd_d  = cmd_q;
        pend_d = pend_q;
        if (!pend_q || cmd_ack) begin
            cmd_d  = ev_code;
            pend_d = (ev_code != CMD_NONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= '0;
            prev_q   <= '0;
            db_cnt_q <= '0;
            cmd_q    <= CMD_NONE;
            pend_q   <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            prev_q   <= state_q;
            db_cnt_q <= db_cnt_d;
            cmd_q    <= cmd_d;
            pend_q   <= pend_d;
        end
    end

    assign controller_out = cmd_q;
    assign cmd_pending    = pend_q;
    assign btn_state      = state_q;

endmodule

// File: tb/tb_tetris_input_encoder.sv
// Bench for tetris_input_encoder: directed scenarios plus random buttons/acks
// checked every cycle against a timestamp-based behavioural model.
module tb_tetris_input_encoder;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
`ifdef TETRIS_AUTO_REPEAT_EN
    localparam bit AUTO_REP = 1'b1;
`else
    localparam bit AUTO_REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] btn_raw;
    logic       cmd_ack;
    logic [3:0] controller_out;
    logic       cmd_pending;
    logic [5:0] btn_state;

    always #5 clk = ~clk;

    tetris_input_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .CNT_W          (25)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .cmd_ack       (cmd_ack),
        .controller_out(controller_out),
        .cmd_pending   (cmd_pending),
        .btn_state     (btn_state)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: edge-indexed timestamps instead of counters.
    logic [5:0] m_s1, m_s2, m_st, m_prev, m_pr;
    int         m_eq_at[6];
    logic [3:0] m_cmd, m_win;
    bit         m_pend, m_rep_on, m_rep_ev;
    int         m_rep_btn, m_arm, m_edge, m_dt;
    int         ORDER[6] = '{4, 3, 5, 2, 0, 1};

    function automatic logic [3:0] btn_code(input int b);
        case (b)
            0:       return 4'd1;
            1:       return 4'd2;
            2:       return 4'd3;
            3:       return 4'd5;
            4:       return 4'd4;
            default: return 4'd6;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_prev = '0;
            m_cmd = '0; m_pend = 1'b0; m_rep_on = 1'b0;
            m_rep_btn = 0; m_arm = 0; m_edge = 0;
            for (int b = 0; b < 6; b++) m_eq_at[b] = 0;
        end else begin
            m_pr = m_st & ~m_prev;
            m_rep_ev = 1'b0;
            if (AUTO_REP && m_rep_on && m_st[m_rep_btn]) begin
                m_dt = m_edge - m_arm;
                if (m_dt >= RD && (m_dt - RD) % RR == 0) m_rep_ev = 1'b1;
            end
            m_win = 4'd0;
            for (int k = 0; k < 6; k++)
                if (m_win == 4'd0 && m_pr[ORDER[k]]) m_win = btn_code(ORDER[k]);
            if (m_win == 4'd0 && m_rep_ev) m_win = btn_code(m_rep_btn);
            if (!m_pend || cmd_ack) begin
                m_cmd  = m_win;
                m_pend = (m_win != 4'd0);
            end
            if (AUTO_REP) begin
                if (|m_pr[2:0]) begin
                    m_rep_on  = 1'b1;
                    m_rep_btn = m_pr[2] ? 2 : (m_pr[0] ? 0 : 1);
                    m_arm     = m_edge;
                end else if (m_rep_on && !m_st[m_rep_btn]) begin
                    m_rep_on = 1'b0;
                end
            end
            m_prev = m_st;
            for (int b = 0; b < 6; b++) begin
                if (m_s2[b] == m_st[b]) begin
                    m_eq_at[b] = m_edge;
                end else if (m_edge - m_eq_at[b] == DB + 1) begin
                    m_st[b]    = ~m_st[b];
                    m_eq_at[b] = m_edge;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            m_edge++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_controller_out", controller_out, m_cmd);
            check("model_cmd_pending", cmd_pending, m_pend);
            check("model_btn_state", btn_state, m_st);
        end
    end

    int   rise0   = 0;
    logic b0_prev = 1'b0;
    always @(negedge clk) begin
        if (btn_state[0] === 1'b1 && b0_prev === 1'b0) rise0++;
        b0_prev = btn_state[0];
    end

    int idx;

    initial begin
        reset   = 1'b1;
        btn_raw = 6'h3F;
        cmd_ack = 1'b0;
        tick(3);
        chk_on = 1'b1;
        check("reset_out", controller_out, 4'h0);
        check("reset_pend", cmd_pending, 1'b0);
        check("reset_state", btn_state, 6'h00);

        reset = 1'b0;
        tick(6);
        check("reset_db_early", btn_state, 6'h00);
        tick(1);
        check("reset_db_state", btn_state, 6'h3F);
        check("reset_no_cmd_yet", controller_out, 4'h0);
        tick(1);
        check("reset_start", {cmd_pending, controller_out}, 5'h14);
        check("model_pin_start", m_cmd, 4'h4);
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
        check("reset_ack_clear", {cmd_pending, controller_out}, 5'h00);
        tick(1);
        btn_raw = 6'h00;
        for (int i = 10; i <= 20; i++) begin
            tick(1);
            check("reset_no_more_cmd", controller_out, 4'h0);
        end

        tick(5);
        rise0 = 0;
        for (int k = 0; k < 5; k++) begin
            btn_raw[0] = 1'b1; tick(2);
            btn_raw[0] = 1'b0; tick(2);
        end
        btn_raw[0] = 1'b1;
        tick(6);
        check("bounce_state_early", btn_state[0], 1'b0);
        tick(1);
        check("bounce_state_rise", btn_state[0], 1'b1);
        tick(1);
        check("bounce_left", controller_out, 4'h1);
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
        btn_raw[0] = 1'b0;
        tick(14);
        check("bounce_one_rise", rise0, 1);
        check("bounce_no_repeat", controller_out, 4'h0);

        btn_raw[4] = 1'b1;
        tick(8);
        check("hs_start", {cmd_pending, controller_out}, 5'h14);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (i == 3) btn_raw[4] = 1'b0;
            check("hs_hold", {cmd_pending, controller_out}, 5'h14);
        end
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
        check("hs_ack_clear", {cmd_pending, controller_out}, 5'h00);
        tick(10);

        btn_raw = 6'b001001;
        tick(8);
        check("prio_rotate", {cmd_pending, controller_out}, 5'h15);
        check("model_pin_rotate", m_cmd, 4'h5);
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
        btn_raw[3] = 1'b0;
        check("prio_ack_clear", controller_out, 4'h0);
`ifdef TETRIS_AUTO_REPEAT_EN
        tick(8);
        check("prio_repeat_early", controller_out, 4'h0);
        tick(1);
        check("prio_repeat_left", {cmd_pending, controller_out}, 5'h11);
        check("model_pin_repeat", m_cmd, 4'h1);
`endif
        btn_raw = 6'h00;
        cmd_ack = 1'b1;
        tick(20);
        cmd_ack = 1'b0;
        tick(5);

`ifdef TETRIS_AUTO_REPEAT_EN
        cmd_ack    = 1'b1;
        btn_raw[1] = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            tick(1);
            check("rep_right",
                  controller_out,
                  (i == 7 || (i >= 17 && (i - 17) % 3 == 0)) ? 4'h2 : 4'h0);
        end
        btn_raw[1] = 1'b0;
        for (int i = 31; i <= 50; i++) begin
            tick(1);
            check("rep_release",
                  controller_out, (i == 32 || i == 35) ? 4'h2 : 4'h0);
            if (i == 36) check("rep_state_high", btn_state[1], 1'b1);
            if (i == 37) check("rep_state_fall", btn_state[1], 1'b0);
        end
        cmd_ack = 1'b0;
        tick(5);
`endif

        btn_raw[2] = 1'b1;
        tick(8);
        check("drop_down", {cmd_pending, controller_out}, 5'h13);
        btn_raw = 6'b010000;
        for (int i = 8; i <= 20; i++) begin
            tick(1);
            check("drop_hold", controller_out, 4'h3);
        end
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
        check("drop_ack_clear", {cmd_pending, controller_out}, 5'h00);
        btn_raw = 6'h00;
        tick(10);

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, 5);
                btn_raw[idx] = ~btn_raw[idx];
            end
            cmd_ack = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        reset   = 1'b0;
        cmd_ack = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
